// File: rtl/spi_master_ctrl_pkg.sv
// Shared definitions for the SPI master: FSM states, frame geometry,
// command encodings and the frame builder used at accept time.
package spi_master_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2,
        ST_GAP   = 2'd3
    } spi_state_e;

    localparam int   FRAME_BITS = 16;
    localparam int   CMD_BITS   = 8;
    localparam logic CMD_READ   = 1'b1;
    localparam logic CMD_WRITE  = 1'b0;

    // Command byte {addr, rw}, then data; reads send zeros in the data half.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [6:0] addr,
        input logic       rw,
        input logic [7:0] wdata
    );
        return {addr, rw, (rw == CMD_READ) ? 8'h00 : wdata};
    endfunction

endpackage

// File: rtl/spi_master_ctrl_clkgen.sv
// SPI clock generator: half-period counter producing sclk plus strobes.
// Ports: clk, reset_n (sync, active-low), en; sclk, rise_tick, fall_tick.
module spi_master_ctrl_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam logic [7:0] TC = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic       term;

    assign term      = en && (cnt_q == TC);
    // Strobes mark the cycle whose closing edge flips sclk.
    assign rise_tick = term && !sclk;
    assign fall_tick = term && sclk;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            sclk  <= 1'b0;
        end else if (!en) begin
            cnt_q <= '0;
            sclk  <= 1'b0;
        end else if (term) begin
            cnt_q <= '0;
            sclk  <= ~sclk;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// Host-side SPI master: one 16-bit mode-0 frame per accepted start.
// Ports: clk, reset_n, start/rw/addr/wdata in; busy, done, rdata out; SPI pins.
module spi_master_ctrl
    import spi_master_ctrl_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk_out,
    output logic       cs_out,
    output logic       mosi_out,
    input  logic       miso_in
);

    localparam logic [7:0] HOLD_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_PEN   = 8'((GAP_CYCLES >= 2) ? GAP_CYCLES - 2 : 0);
    localparam logic [3:0] LAST_BIT  = 4'(FRAME_BITS - 1);
    localparam logic [3:0] DATA_BIT  = 4'(CMD_BITS);

    spi_state_e       state_q, state_d;
    logic [7:0]       cnt_q;
    logic [3:0]       bit_cnt_q;
    logic [15:0]      shreg_q;
    logic [15:0]      frame;
    logic [7:0]       rx_q;
    logic             rw_q;
    logic             rise_tick, fall_tick;
    logic             load, hold_end, gap_last_d;

    assign frame = build_frame(addr, rw, wdata);

    spi_master_ctrl_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (state_q == ST_SHIFT),
        .sclk      (sclk_out),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    assign hold_end = (state_q == ST_HOLD) && (cnt_q == HOLD_LAST);

    // High when the next cycle is the last GAP cycle, so done, busy and
    // rdata all register together and line up with that cycle.
    assign gap_last_d = (GAP_CYCLES == 1) ? hold_end :
                        ((state_q == ST_GAP) && (cnt_q == GAP_PEN) && !done);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (fall_tick && (bit_cnt_q == LAST_BIT)) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_end) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (done) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            rx_q      <= '0;
            rw_q      <= 1'b0;
            cs_out    <= 1'b1;
            mosi_out  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rdata     <= '0;
        end else begin
            state_q <= state_d;

            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (state_q == ST_HOLD || state_q == ST_GAP) begin
                cnt_q <= cnt_q + 8'd1;
            end else begin
                cnt_q <= '0;
            end

            if (load) begin
                shreg_q   <= frame;
                rw_q      <= rw;
                bit_cnt_q <= '0;
                rx_q      <= '0;
                cs_out    <= 1'b0;
                mosi_out  <= frame[15];
                busy      <= 1'b1;
            end

            // miso is sampled on the rising edge of each data bit.
            if (rise_tick && (bit_cnt_q >= DATA_BIT) && (rw_q == CMD_READ)) begin
                rx_q <= {rx_q[6:0], miso_in};
            end

            if (fall_tick) begin
                shreg_q   <= {shreg_q[14:0], 1'b0};
                mosi_out  <= shreg_q[14];
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end

            if (hold_end) begin
                cs_out   <= 1'b1;
                mosi_out <= 1'b0;
            end

            done <= gap_last_d;
            if (gap_last_d) begin
                busy <= 1'b0;
                if (rw_q == CMD_READ) begin
                    rdata <= rx_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural SPI memory slave.
// A second instance runs CLK_DIV=6, GAP_CYCLES=3 for phase/gap timing.
module tb_spi_master_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start, rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy, done;
    logic [7:0] rdata;
    logic       sclk_out, cs_out, mosi_out;
    logic       miso = 1'b0;

    logic       start2;
    logic       busy2, done2;
    logic [7:0] rdata2;
    logic       sclk_out2, cs_out2, mosi_out2;
    logic       miso2 = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spi_master_ctrl #(.CLK_DIV(4), .GAP_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .rw(rw),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .rdata(rdata), .sclk_out(sclk_out), .cs_out(cs_out),
        .mosi_out(mosi_out), .miso_in(miso)
    );

    spi_master_ctrl #(.CLK_DIV(6), .GAP_CYCLES(3)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .rw(1'b0),
        .addr(7'h01), .wdata(8'h3C), .busy(busy2), .done(done2),
        .rdata(rdata2), .sclk_out(sclk_out2), .cs_out(cs_out2),
        .mosi_out(mosi_out2), .miso_in(miso2)
    );

    // Behavioural SPI memory (mode 0) on the first instance.
    logic [7:0]  mem [128];
    logic [15:0] s_cap = '0;
    logic [7:0]  s_cmd = '0;
    logic [7:0]  s_rd  = '0;
    int          s_rise = 0;
    int          s_fall = 0;
    int          cs_falls = 0;

    always @(negedge cs_out) begin
        s_rise = 0;
        s_fall = 0;
        s_cap  = '0;
        miso   = 1'b0;
        cs_falls++;
    end

    always @(posedge sclk_out) begin
        if (cs_out === 1'b0) begin
            s_cap = {s_cap[14:0], mosi_out};
            s_rise++;
        end
    end

    always @(negedge sclk_out) begin
        if (cs_out === 1'b0) begin
            s_fall++;
            if (s_fall == 8) begin
                s_cmd = s_cap[7:0];
                s_rd  = mem[s_cmd[7:1]];
            end
            if (s_fall >= 8 && s_fall <= 15 && s_cmd[0])
                miso = s_rd[15 - s_fall];
            else
                miso = 1'b0;
        end
    end

    always @(posedge cs_out) begin
        if (s_rise == 16 && s_cap[8] == 1'b0)
            mem[s_cap[15:9]] = s_cap[7:0];
    end

    task automatic run_frame(
        input  logic       r,
        input  logic [6:0] a,
        input  logic [7:0] w,
        input  bit         extra,
        output int         done_at,
        output int         cs_low,
        output logic       busy_d,
        output logic [7:0] rdata_d,
        output bit         timed_out
    );
        done_at   = -1;
        cs_low    = 0;
        busy_d    = 1'bx;
        rdata_d   = 'x;
        timed_out = 1'b1;
        @(negedge clk);
        start = 1'b1; rw = r; addr = a; wdata = w;
        @(negedge clk);
        start = 1'b0; rw = ~r; addr = ~a; wdata = ~w;
        for (int n = 1; n <= 400; n++) begin
            if (cs_out == 1'b0) cs_low++;
            if (done) begin
                done_at   = n;
                busy_d    = busy;
                rdata_d   = rdata;
                timed_out = 1'b0;
                start     = extra;
                @(negedge clk);
                start = 1'b0;
                break;
            end
            start = extra && (n == 10 || n == 60);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (cs_out !== 1'b1) begin
            n_fail++; $display("FAIL reset_cs got %b want 1", cs_out);
        end
        n_tests++;
        if (sclk_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_sclk got %b want 0", sclk_out);
        end
        n_tests++;
        if (mosi_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_mosi got %b want 0", mosi_out);
        end
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy_done got %b%b want 00", busy, done);
        end
        n_tests++;
        if (rdata !== 8'h00) begin
            n_fail++; $display("FAIL reset_rdata got %h want 00", rdata);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        int d, l, extra_done;
        logic b;
        logic [7:0] rd;
        bit to;
        run_frame(1'b0, 7'h12, 8'h5A, 1'b0, d, l, b, rd, to);
        n_tests++;
        if (to) begin
            n_fail++; $display("FAIL write_timeout got no done want done");
        end
        // cs low for 33*4 cycles, done in the last of 8 GAP cycles.
        n_tests++;
        if (l != 132) begin
            n_fail++; $display("FAIL write_cs_low got %0d want 132", l);
        end
        n_tests++;
        if (d != 140) begin
            n_fail++; $display("FAIL write_done_at got %0d want 140", d);
        end
        n_tests++;
        if (s_cap !== 16'h245A) begin
            n_fail++; $display("FAIL write_mosi got %h want 245a", s_cap);
        end
        n_tests++;
        if (rd !== 8'h00) begin
            n_fail++; $display("FAIL write_rdata got %h want 00", rd);
        end
        extra_done = 0;
        repeat (20) begin
            if (done) extra_done++;
            @(negedge clk);
        end
        n_tests++;
        if (extra_done != 0) begin
            n_fail++; $display("FAIL write_done_once got %0d extra want 0", extra_done);
        end
        n_tests++;
        if (mem[7'h12] !== 8'h5A) begin
            n_fail++; $display("FAIL write_mem got %h want 5a", mem[7'h12]);
        end
    endtask

    task automatic test_read();
        int d, l;
        logic b;
        logic [7:0] rd;
        bit to;
        mem[7'h12] = 8'hC3;
        run_frame(1'b1, 7'h12, 8'hFF, 1'b0, d, l, b, rd, to);
        n_tests++;
        if (to || d != 140) begin
            n_fail++; $display("FAIL read_done_at got %0d want 140", d);
        end
        n_tests++;
        if (s_cap[15:8] !== 8'h25) begin
            n_fail++; $display("FAIL read_cmd got %h want 25", s_cap[15:8]);
        end
        n_tests++;
        if (s_cap[7:0] !== 8'h00) begin
            n_fail++; $display("FAIL read_mosi_data got %h want 00", s_cap[7:0]);
        end
        n_tests++;
        if (rd !== 8'hC3) begin
            n_fail++; $display("FAIL read_rdata got %h want c3", rd);
        end
        n_tests++;
        if (b !== 1'b0) begin
            n_fail++; $display("FAIL read_busy_at_done got %b want 0", b);
        end
    endtask

    task automatic test_mem_loop();
        int d, l;
        logic b;
        logic [7:0] rd;
        bit to;
        run_frame(1'b0, 7'h05, 8'hA7, 1'b0, d, l, b, rd, to);
        run_frame(1'b1, 7'h05, 8'h00, 1'b0, d, l, b, rd, to);
        n_tests++;
        if (to || rd !== 8'hA7) begin
            n_fail++; $display("FAIL loop_rd5 got %h want a7", rd);
        end
        run_frame(1'b1, 7'h06, 8'h00, 1'b0, d, l, b, rd, to);
        n_tests++;
        if (to || rd !== 8'hA6) begin
            n_fail++; $display("FAIL loop_rd6 got %h want a6", rd);
        end
    endtask

    task automatic test_start_while_busy();
        int d, l, f0;
        logic b;
        logic [7:0] rd;
        bit to;
        f0 = cs_falls;
        run_frame(1'b0, 7'h20, 8'h33, 1'b1, d, l, b, rd, to);
        repeat (200) @(negedge clk);
        n_tests++;
        if (to || cs_falls - f0 != 1) begin
            n_fail++; $display("FAIL busy_start_frames got %0d want 1", cs_falls - f0);
        end
        n_tests++;
        if (busy !== 1'b0 || cs_out !== 1'b1) begin
            n_fail++; $display("FAIL busy_start_idle got busy=%b cs=%b want 0 1", busy, cs_out);
        end
        run_frame(1'b0, 7'h21, 8'h44, 1'b0, d, l, b, rd, to);
        n_tests++;
        if (to || d != 140 || mem[7'h21] !== 8'h44) begin
            n_fail++; $display("FAIL busy_start_next got done_at=%0d mem=%h want 140 44", d, mem[7'h21]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int d, l, w;
        logic b;
        logic [7:0] rd;
        bit to;
        @(negedge clk);
        start = 1'b1; rw = 1'b0; addr = 7'h05; wdata = 8'hEE;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (s_rise < 5 && w < 200) begin
            @(negedge clk);
            w++;
        end
        n_tests++;
        if (s_rise != 5) begin
            n_fail++; $display("FAIL rst_mid_reach got %0d rises want 5", s_rise);
        end
        reset_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (cs_out !== 1'b1 || sclk_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_pins got cs=%b sclk=%b busy=%b done=%b want 1 0 0 0",
                     cs_out, sclk_out, busy, done);
        end
        n_tests++;
        if (rdata !== 8'h00) begin
            n_fail++; $display("FAIL rst_mid_rdata got %h want 00", rdata);
        end
        reset_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done) begin
                n_tests++; n_fail++;
                $display("FAIL rst_mid_done got 1 want 0");
            end
        end
        n_tests++;
        if (mem[7'h05] !== 8'hA7) begin
            n_fail++; $display("FAIL rst_mid_nowrite got %h want a7", mem[7'h05]);
        end
        run_frame(1'b0, 7'h05, 8'h11, 1'b0, d, l, b, rd, to);
        n_tests++;
        if (to || d != 140 || mem[7'h05] !== 8'h11) begin
            n_fail++; $display("FAIL rst_mid_after got done_at=%0d mem=%h want 140 11", d, mem[7'h05]);
        end
    endtask

    task automatic test_back_to_back();
        logic s, c, ps, pc;
        int run, hrun, runs, bad, gaps, badgap, rises;
        bit seen;
        ps = sclk_out2; pc = cs_out2;
        run = 0; hrun = 0; runs = 0; bad = 0;
        gaps = 0; badgap = 0; rises = 0; seen = 1'b0;
        @(negedge clk);
        start2 = 1'b1;
        for (int n = 0; n < 2000 && rises < 3; n++) begin
            @(negedge clk);
            s = sclk_out2; c = cs_out2;
            if (c == 1'b0 && pc == 1'b0 && s == ps) begin
                run++;
            end else begin
                if (pc == 1'b0) begin
                    runs++;
                    if (run != 6) bad++;
                end
                run = 1;
            end
            if (c == 1'b1) hrun = (pc == 1'b1) ? hrun + 1 : 1;
            // cs-high between frames: 3 GAP cycles plus the accepting IDLE cycle.
            if (c == 1'b0 && pc == 1'b1 && seen) begin
                gaps++;
                if (hrun != 4) badgap++;
            end
            if (c == 1'b1 && pc == 1'b0) begin
                rises++;
                seen = 1'b1;
            end
            ps = s; pc = c;
        end
        start2 = 1'b0;
        n_tests++;
        if (rises != 3) begin
            n_fail++; $display("FAIL b2b_frames got %0d want 3", rises);
        end
        n_tests++;
        if (runs != 99 || bad != 0) begin
            n_fail++; $display("FAIL b2b_phases got runs=%0d bad=%0d want 99 0", runs, bad);
        end
        n_tests++;
        if (gaps != 2 || badgap != 0) begin
            n_fail++; $display("FAIL b2b_gap got gaps=%0d bad=%0d want 2 0", gaps, badgap);
        end
        repeat (20) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'(8'hA0 + i);
        start = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        start2 = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_mem_loop();
        test_start_while_busy();
        test_reset_mid_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
